// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Input conditioner for N_CH mechanical switches / footswitches. Each channel
//   runs a SYNC_STAGES-deep synchroniser, then a counter-based debouncer that
//   only accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing
//   samples. It also produces one-cycle rise/fall pulses and a footswitch-style
//   toggle latch.
// Ports
//   sys_clk    in   1     system clock, rising edge
//   reset      in   1     synchronous reset, active-high
//   sw_in      in   N_CH  raw asynchronous switch pins
//   sw_level   out  N_CH  debounced stable level
//   sw_rise    out  N_CH  one-cycle pulse on accepted 0->1
//   sw_fall    out  N_CH  one-cycle pulse on accepted 1->0
//   sw_toggle  out  N_CH  flips on every accepted rising edge
//   sw_any     out  1     one-cycle pulse when any channel accepts a change

// Per-channel conditioner: synchroniser, debounce counter, edge and toggle regs.
module switch_debounce_ch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit INIT_VAL        = 1'b0
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic sw_in,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall,
    output logic sw_toggle,
    output logic accept      // combinational: level changes at the next edge
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_q;
    logic                   mismatch;

    assign sync_q   = sync_r[SYNC_STAGES-1];
    assign mismatch = sync_q ^ sw_level;
    // With DEBOUNCE_CYCLES == 1 the counter sits at 0 == CNT_MAX, so any
    // mismatch is accepted straight away.
    assign accept   = mismatch && (cnt == CNT_MAX);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync_r    <= {SYNC_STAGES{INIT_VAL}};
            cnt       <= '0;
            sw_level  <= INIT_VAL;
            sw_toggle <= INIT_VAL;
            sw_rise   <= 1'b0;
            sw_fall   <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], sw_in};
            sw_rise <= accept &  sync_q;
            sw_fall <= accept & ~sync_q;
            if (accept) begin
                sw_level <= sync_q;
                cnt      <= '0;
            end else if (mismatch) begin
                cnt <= cnt + 1'b1;
            end else begin
                // Any sample back at the current level forfeits the run.
                cnt <= '0;
            end
            if (accept && sync_q)
                sw_toggle <= ~sw_toggle;
        end
    end
endmodule

module switch_debouncer #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit INIT_VAL        = 1'b0
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_level,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall,
    output logic [N_CH-1:0] sw_toggle,
    output logic            sw_any
);
    logic [N_CH-1:0] accept_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        switch_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT_VAL       (INIT_VAL)
        ) u_ch (
            .sys_clk  (sys_clk),
            .reset    (reset),
            .sw_in    (sw_in[i]),
            .sw_level (sw_level[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i]),
            .sw_toggle(sw_toggle[i]),
            .accept   (accept_v[i])
        );
    end

    // Registered from the pre-edge accept terms so it lines up with the
    // per-channel pulses and stays a single cycle however many channels fire.
    always_ff @(posedge sys_clk) begin
        if (reset)
            sw_any <= 1'b0;
        else
            sw_any <= |accept_v;
    end
endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer. A reference model, driven on each rising
// edge, pushes the expected outputs into a scoreboard. A monitor on the
// falling edge pops each entry and compares it with the DUT. The model says
// a channel accepts a new value once the last D synchronised samples all
// differ from its current level. A second DUT built with DEBOUNCE_CYCLES=1
// is modelled as the raw input delayed by three edges.
module tb_switch_debouncer;
    localparam int N = 4;
    localparam int S = 2;
    localparam int D = 4;
    localparam bit INIT = 1'b0;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] tog;
        logic         any;
        logic         l1;
        logic         r1;
        logic         f1;
        logic         t1;
        logic         a1;
    } exp_t;

    typedef struct {
        int id;
        int expv;
    } chk_t;

    logic         sys_clk = 1'b0;
    logic         reset;
    logic [N-1:0] sw_in, sw_level, sw_rise, sw_fall, sw_toggle;
    logic         sw_any;
    logic [0:0]   sw1_in, l1, r1, f1, t1;
    logic         a1;

    switch_debouncer #(
        .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .INIT_VAL(INIT)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .sw_in(sw_in),
        .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .sw_toggle(sw_toggle), .sw_any(sw_any)
    );

    switch_debouncer #(
        .N_CH(1), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(1), .INIT_VAL(INIT)
    ) dut1 (
        .sys_clk(sys_clk), .reset(reset), .sw_in(sw1_in),
        .sw_level(l1), .sw_rise(r1), .sw_fall(f1),
        .sw_toggle(t1), .sw_any(a1)
    );

    always #5 sys_clk = ~sys_clk;

    exp_t sb[$];
    chk_t dq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // ---------------- reference model ----------------
    bit [S-1:0] m_sync [N];
    bit [D-1:0] m_win  [N];
    int         m_wn   [N];
    bit [N-1:0] m_lvl, m_tog;
    bit [2:0]   h1;
    bit         m_l1, m_t1, nl, sq;
    exp_t       e_m;

    always @(posedge sys_clk) begin
        e_m = '0;
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                m_sync[c] = {S{INIT}};
                m_win[c]  = '0;
                m_wn[c]   = 0;
            end
            m_lvl = {N{INIT}};
            m_tog = {N{INIT}};
            h1    = {3{INIT}};
            m_l1  = INIT;
            m_t1  = INIT;
        end else begin
            for (int c = 0; c < N; c++) begin
                sq = m_sync[c][S-1];
                m_win[c] = {m_win[c][D-2:0], sq};
                if (m_wn[c] < D) m_wn[c]++;
                if (m_wn[c] == D && m_win[c] == {D{~m_lvl[c]}}) begin
                    m_lvl[c] = sq;
                    m_wn[c]  = 0;
                    if (sq) begin
                        e_m.rise[c] = 1'b1;
                        m_tog[c]    = ~m_tog[c];
                    end else begin
                        e_m.fall[c] = 1'b1;
                    end
                end
                m_sync[c] = {m_sync[c][S-2:0], sw_in[c]};
            end
            h1 = {h1[1:0], sw1_in[0]};
            nl = h1[2];
            e_m.r1 = nl & ~m_l1;
            e_m.f1 = ~nl & m_l1;
            if (e_m.r1) m_t1 = ~m_t1;
            m_l1 = nl;
        end
        e_m.lvl = m_lvl;
        e_m.tog = m_tog;
        e_m.any = |(e_m.rise | e_m.fall);
        e_m.l1  = m_l1;
        e_m.t1  = m_t1;
        e_m.a1  = e_m.r1 | e_m.f1;
        sb.push_back(e_m);
    end

    // ---------------- monitor ----------------
    exp_t e_c, a_c;
    chk_t ck;
    int   act;
    int   cnt_p1 = 0, cnt_r2 = 0, cnt_f2 = 0, cnt_pd1 = 0;

    always @(negedge sys_clk) begin
        if (reset) begin
            cnt_p1 = 0; cnt_r2 = 0; cnt_f2 = 0; cnt_pd1 = 0;
        end else begin
            cnt_p1  += int'(sw_rise[1]) + int'(sw_fall[1]);
            cnt_r2  += int'(sw_rise[2]);
            cnt_f2  += int'(sw_fall[2]);
            cnt_pd1 += int'(r1[0]) + int'(f1[0]);
        end
        if (sb.size() > 0) begin
            e_c = sb.pop_front();
            a_c = {sw_level, sw_rise, sw_fall, sw_toggle, sw_any,
                   l1[0], r1[0], f1[0], t1[0], a1};
            vectors++;
            if (a_c !== e_c) begin
                miscompares++;
                $display("FAIL outputs t=%0t got=%h exp=%h", $time, a_c, e_c);
            end
        end
        if (dq.size() > 0) begin
            ck = dq.pop_front();
            case (ck.id)
                0:       act = cnt_p1;
                1:       act = cnt_r2;
                2:       act = cnt_f2;
                3:       act = int'(sw_toggle[2]);
                4:       act = int'(sw_level[3]);
                5:       act = int'(sw_level[1]);
                default: act = cnt_pd1;
            endcase
            vectors++;
            if (act != ck.expv) begin
                miscompares++;
                $display("FAIL check%0d got=%0d exp=%0d", ck.id, act, ck.expv);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push_chk(input int id, input int expv);
        chk_t c;
        c.id = id;
        c.expv = expv;
        dq.push_back(c);
    endtask

    int hold [N];
    int hold1;

    initial begin
        // 1: reset with all pins high, then release
        reset = 1'b1; sw_in = 4'hF; sw1_in = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(12);
        // 2: all low, then a clean step on ch0
        sw_in = 4'h0;
        tick(12);
        sw_in[0] = 1'b1;
        tick(12);
        // 3: ch1 glitches shorter than the debounce window, then a real press
        reset = 1'b1; sw_in = 4'h0;
        tick(2);
        reset = 1'b0;
        tick(4);
        sw_in[1] = 1'b1; tick(3);
        sw_in[1] = 1'b0; tick(1);
        sw_in[1] = 1'b1; tick(3);
        sw_in[1] = 1'b0; tick(10);
        push_chk(0, 0);
        sw_in[1] = 1'b1; tick(10);
        push_chk(5, 1);
        // 4: ch2 pressed/released three times
        reset = 1'b1; sw_in = 4'h0;
        tick(2);
        reset = 1'b0;
        tick(2);
        for (int k = 0; k < 3; k++) begin
            sw_in[2] = 1'b1; tick(10);
            sw_in[2] = 1'b0; tick(10);
        end
        tick(4);
        push_chk(1, 3);
        push_chk(2, 3);
        push_chk(3, 1);
        tick(2);
        // 5: ch3 pending count killed by reset
        sw_in[3] = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        push_chk(4, 0);
        tick(12);
        // 6: D=1 instance, pin toggled every 2 cycles
        for (int k = 0; k < 10; k++) begin
            sw1_in = ~sw1_in;
            tick(2);
        end
        tick(6);
        push_chk(6, 10);
        tick(2);
        // randomized bounce/hold patterns with occasional resets
        for (int c = 0; c < N; c++) hold[c] = 0;
        hold1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    sw_in[c] = ~sw_in[c];
                    hold[c]  = int'($urandom_range(1, 8));
                end else begin
                    hold[c]--;
                end
            end
            if (hold1 == 0) begin
                sw1_in = ~sw1_in;
                hold1  = int'($urandom_range(0, 3));
            end else begin
                hold1--;
            end
            reset = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
